// File: rtl/clk_capture.sv
// Input-capture unit: measures period and high time of cap_in in i_wb_clk cycles.
// Counters saturate at 2^WIDTH-1 and flag the measurement as overflowed.
module clk_capture #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst,
    input  logic             cap_en,
    input  logic             cap_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             cap_valid,
    output logic             cap_ovf
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t           r_state;
    logic [SS-1:0]    r_sync;
    logic             r_s_d;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi_lat;
    logic             r_ovf_flag;

    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic             w_sat;
    logic [WIDTH-1:0] w_cnt_inc;

    assign w_s       = r_sync[SS-1];
    assign w_rise    = w_s & ~r_s_d;
    assign w_fall    = ~w_s & r_s_d;
    assign w_sat     = (r_cnt == CNT_MAX);
    assign w_cnt_inc = w_sat ? CNT_MAX : (r_cnt + CNT_ONE);

    // Synchronizer chain plus one-cycle delayed copy for edge detection
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SS-2:0], cap_in};
            r_s_d  <= w_s;
        end
    end

    // Measurement FSM; a report and the start of the next period share one edge
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hi_lat   <= '0;
            r_ovf_flag <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            cap_valid  <= 1'b0;
            cap_ovf    <= 1'b0;
        end else begin
            cap_valid <= 1'b0;
            if (!cap_en) begin
                r_state    <= IDLE;
                r_cnt      <= '0;
                r_ovf_flag <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= ARM;
                        r_cnt      <= '0;
                        r_ovf_flag <= 1'b0;
                    end
                    ARM: begin
                        if (w_rise) begin
                            r_state    <= HIGH;
                            r_cnt      <= CNT_ONE;
                            r_ovf_flag <= 1'b0;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    HIGH: begin
                        r_cnt <= w_cnt_inc;
                        if (w_sat) begin
                            r_ovf_flag <= 1'b1;
                        end
                        if (w_fall) begin
                            r_hi_lat <= r_cnt;
                            r_state  <= LOW;
                        end
                    end
                    LOW: begin
                        if (w_rise) begin
                            period     <= r_cnt;
                            high_time  <= r_hi_lat;
                            cap_ovf    <= r_ovf_flag;
                            cap_valid  <= 1'b1;
                            r_cnt      <= CNT_ONE;
                            r_ovf_flag <= 1'b0;
                            r_state    <= HIGH;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_sat) begin
                                r_ovf_flag <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_capture.sv
// Self-checking bench for clk_capture: two instances (2 and 3 sync stages) against
// a timestamp-based reference model, plus directed literal checks.
module tb_clk_capture;

    localparam int          MAXV   = 65535;
    localparam logic [1:0]  M_OFF  = 2'd0;
    localparam logic [1:0]  M_WAIT = 2'd1;
    localparam logic [1:0]  M_MEAS = 2'd2;

    typedef struct packed {
        logic [1:0]  mode;
        int          last_rise;
        int          last_fall;
        logic [15:0] period;
        logic [15:0] high;
        logic        valid;
        logic        ovf;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cin;
    logic [15:0] p2, h2o, p3, h3o;
    logic        v2, o2, v3, o3;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cnt2   = 0;
    int   c0;
    int   lat2, lat3;
    int   ecount = 0;
    bit   chk_on = 1'b0;
    logic [15:0] lp2, lh2;
    logic        lo2;
    logic [7:0]  hs2 = 8'h00;
    logic [7:0]  hs3 = 8'h00;
    mdl_t        m2;
    mdl_t        m3;

    clk_capture #(.WIDTH(16), .SYNC_STAGES(2)) u_dut2 (
        .i_wb_clk(clk), .i_wb_rst(rst), .cap_en(en), .cap_in(cin),
        .period(p2), .high_time(h2o), .cap_valid(v2), .cap_ovf(o2)
    );

    clk_capture #(.WIDTH(16), .SYNC_STAGES(3)) u_dut3 (
        .i_wb_clk(clk), .i_wb_rst(rst), .cap_en(en), .cap_in(cin),
        .period(p3), .high_time(h3o), .cap_valid(v3), .cap_ovf(o3)
    );

    always #5 clk = ~clk;

    // Reference: period and high time are differences of edge timestamps, clamped
    function automatic mdl_t mstep(input mdl_t m, input logic s, input logic sd,
                                   input logic r, input logic e_n, input int t);
        mdl_t n;
        int   k;
        int   h;
        n = m;
        n.valid = 1'b0;
        if (r) begin
            n = '0;
        end else if (!e_n) begin
            n.mode = M_OFF;
        end else if (m.mode == M_OFF) begin
            n.mode = M_WAIT;
        end else if (s && !sd) begin
            if (m.mode == M_MEAS) begin
                k = t - m.last_rise;
                h = m.last_fall - m.last_rise;
                n.period = (k > MAXV) ? 16'hFFFF : k[15:0];
                n.high   = (h > MAXV) ? 16'hFFFF : h[15:0];
                n.ovf    = (k > MAXV);
                n.valid  = 1'b1;
            end
            n.mode      = M_MEAS;
            n.last_rise = t;
        end else if (!s && sd && m.mode == M_MEAS) begin
            n.last_fall = t;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int i = 0; i < reps; i++) begin
            cin = 1'b1;
            repeat (hi) tick();
            cin = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic rtick();
        if ($urandom_range(0, 63) == 0) en = ~en;
        rst = ($urandom_range(0, 255) == 0);
        tick();
        rst = 1'b0;
    endtask

    // Advance the model; the history registers model the synchronizer delay
    always @(posedge clk) begin
        m2     <= mstep(m2, hs2[1], hs2[2], rst, en, ecount);
        m3     <= mstep(m3, hs3[2], hs3[3], rst, en, ecount);
        hs2    <= rst ? 8'h00 : {hs2[6:0], cin};
        hs3    <= rst ? 8'h00 : {hs3[6:0], cin};
        ecount <= ecount + 1;
    end

    // Compare both instances against the model every cycle
    always @(negedge clk) begin
        if (chk_on) begin
            check("dut2 {period,high,valid,ovf}", {30'd0, p2, h2o, v2, o2},
                  {30'd0, m2.period, m2.high, m2.valid, m2.ovf});
            check("dut3 {period,high,valid,ovf}", {30'd0, p3, h3o, v3, o3},
                  {30'd0, m3.period, m3.high, m3.valid, m3.ovf});
            if (v2) begin
                cnt2++;
                lp2 = p2;
                lh2 = h2o;
                lo2 = o2;
            end
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        cin = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        check("reset period", {48'd0, p2}, 64'd0);
        check("reset high_time", {48'd0, h2o}, 64'd0);
        check("reset cap_valid", {63'd0, v2}, 64'd0);
        check("reset cap_ovf", {63'd0, o2}, 64'd0);

        rst = 1'b0;
        en  = 1'b1;
        repeat (3) tick();
        cnt2 = 0;
        wave(3, 5, 4);
        check("3/5 strobe count", 64'(cnt2), 64'd3);
        check("3/5 period", {48'd0, lp2}, 64'd8);
        check("3/5 high_time", {48'd0, lh2}, 64'd3);
        check("3/5 ovf", {63'd0, lo2}, 64'd0);

        wave(3, 4, 4);
        check("div7 period", {48'd0, lp2}, 64'd7);
        check("div7 high_time", {48'd0, lh2}, 64'd3);

        c0 = cnt2;
        wave(1, 1, 10);
        check("div2 strobe count", 64'(cnt2 - c0), 64'd9);
        check("div2 period", {48'd0, lp2}, 64'd2);
        check("div2 high_time", {48'd0, lh2}, 64'd1);

        cin = 1'b1;
        repeat (70000) tick();
        cin = 1'b0;
        repeat (10) tick();
        cin = 1'b1;
        repeat (3) tick();
        check("stuck valid", {63'd0, v2}, 64'd1);
        check("stuck period", {48'd0, p2}, 64'd65535);
        check("stuck high_time", {48'd0, h2o}, 64'd65535);
        check("stuck ovf", {63'd0, o2}, 64'd1);
        cin = 1'b0;
        repeat (5) tick();
        wave(3, 5, 2);
        check("post-ovf period", {48'd0, lp2}, 64'd8);
        check("post-ovf ovf", {63'd0, lo2}, 64'd0);

        en = 1'b0;
        c0 = cnt2;
        wave(3, 5, 2);
        check("disabled no strobe", 64'(cnt2 - c0), 64'd0);
        check("disabled period hold", {48'd0, p2}, 64'd8);
        check("disabled high hold", {48'd0, h2o}, 64'd3);

        en = 1'b1;
        c0 = cnt2;
        wave(3, 5, 3);
        check("re-enable strobe count", 64'(cnt2 - c0), 64'd2);
        check("re-enable period", {48'd0, lp2}, 64'd8);

        cin = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid reset period", {48'd0, p2}, 64'd0);
        check("mid reset high_time", {48'd0, h2o}, 64'd0);
        check("mid reset cap_valid", {63'd0, v2}, 64'd0);
        check("mid reset cap_ovf", {63'd0, o2}, 64'd0);
        rst = 1'b0;
        cin = 1'b0;
        repeat (4) tick();
        c0 = cnt2;
        wave(3, 5, 3);
        check("post-reset strobe count", 64'(cnt2 - c0), 64'd2);

        cin = 1'b0;
        repeat (5) tick();
        cin  = 1'b1;
        lat2 = 0;
        lat3 = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (v2 && lat2 == 0) lat2 = k;
            if (v3 && lat3 == 0) lat3 = k;
        end
        check("latency SS=2", 64'(lat2), 64'd3);
        check("latency SS=3", 64'(lat3), 64'd4);
        cin = 1'b0;
        repeat (6) tick();

        for (int i = 0; i < 800; i++) begin
            cin = 1'b1;
            repeat ($urandom_range(1, 12)) rtick();
            cin = 1'b0;
            repeat ($urandom_range(1, 12)) rtick();
        end
        rst = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_capture.md
# clk_capture

Input-capture unit for the PWM timer: measures period and high time of an external or internally generated waveform (e.g. a divided clock or PWM output looped back) in units of `i_wb_clk` cycles. It is the measuring counterpart to the clock divider: a waveform divided by N reads back as period N. Results go to the register file as a 16-bit period/high-time pair with a one-cycle valid strobe.

## Interface
- `WIDTH`, 16, width of period/high counters and outputs
- `SYNC_STAGES`, 2, flip-flops in the input synchronizer (min 2)

- `i_wb_clk`  input  1  system clock; all logic on rising edge
- `i_wb_rst`  input  1  reset, synchronous and active-high
- `cap_en`  input  1  capture enable from register file
- `cap_in`  input  1  asynchronous waveform to measure
- `period`  output  WIDTH  cycles between last two rising edges
- `high_time`  output  WIDTH  cycles input was high within that period
- `cap_valid`  output  1  one-cycle strobe when `period`/`high_time` update
- `cap_ovf`  output  1  set with `cap_valid` if the measurement saturated

## Operation
- `cap_in` passes through SYNC_STAGES flops to `s`; `s_d` is `s` delayed one cycle. Rise = `s & ~s_d`; fall = `~s & s_d`.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: counters held at 0. `cap_en`=1 -> ARM.
  - ARM: waits for first rise; on rise -> HIGH, `cnt`<=1. No result from the partial first period.
  - HIGH: `cnt` increments; on fall: `hi_lat`<=`cnt`, -> LOW.
  - LOW: `cnt` increments; on rise: `period`<=`cnt`, `high_time`<=`hi_lat`, `cap_ovf`<=`ovf_flag`, `cap_valid`<=1, `cnt`<=1, `ovf_flag`<=0, -> HIGH.
  - `cap_en`=0 in any state -> IDLE next cycle; no strobe; `period`/`high_time`/`cap_ovf` keep last values.
- Arithmetic: `cnt` is WIDTH bits, saturates at 2^WIDTH-1 and sets `ovf_flag`. If `ovf_flag` is set on fall, `hi_lat` takes the saturated value. Period and high time are never truncated modulo 2^WIDTH.
- Stuck input (no edges): `cnt` stays saturated and no strobe fires. The next valid rise reports `period`=2^WIDTH-1 and `cap_ovf`=1.
- A new measurement starts on the same cycle the previous one is reported. Back-to-back periods each produce one strobe.
- Pulses shorter than one `i_wb_clk` cycle may be missed. This is not an error.

## Timing
- Reset values: `period`=0, `high_time`=0, `cap_valid`=0, `cap_ovf`=0. Reset also clears the FSM to IDLE, `cnt`=0, `hi_lat`=0, `ovf_flag`=0, and the synchronizer flops to 0.
- Reset takes effect on the next `i_wb_clk` edge and overrides `cap_en`. Reset mid-measurement discards the partial result with no strobe.
- Latency: a `cap_in` rising edge sampled at cycle t produces `cap_valid` at cycle t+SYNC_STAGES+1.
- `cap_valid` is high exactly one cycle per completed period. Outputs are stable between strobes.
- Resolution is ±1 `i_wb_clk` cycle for asynchronous inputs. For inputs synchronous to `i_wb_clk` the result is exact: period P, high H read back as P, H.
- If rise and `cap_en` falling occur on the same cycle, disable wins and there is no strobe.

## Test plan
- Synchronous square wave, 3 cycles high / 5 low, `cap_en`=1: first strobe at the second rise with `period`=8, `high_time`=3, `cap_ovf`=0. Every later 8 cycles, identical strobes.
- Divide-by-7 waveform (3 high / 4 low): `period`=7, `high_time`=3. Divide-by-2 (1/1): `period`=2, `high_time`=1, strobe every 2 cycles.
- Input held high 70000 cycles, then low 10, then rise: `period`=65535, `high_time`=65535, `cap_ovf`=1. The next normal 8-cycle period gives `cap_ovf`=0.
- Deassert `cap_en` mid-period: no strobe, outputs hold the previous 8/3. Re-enable: the first partial period is ignored, the next full period is reported.
- Assert `i_wb_rst` for 1 cycle mid-measurement: next cycle all outputs are 0. Measurement resumes with ARM behaviour, first strobe after two rises.
- Edge latency check with SYNC_STAGES=3: strobe appears 4 cycles after the sampled rise.
